fetch_ctrl: RTL and testbench

Fetch controller that sits directly upstream of the SRAM fetch unit. It owns the PC, issues one fetch request per cycle into the fetch unit's fixed two-cycle `req`/`addr` → `rvalid_out`/`rdata_out` path, and buffers returned instructions in a small queue. The queue drives a valid/ready handshake to the decoder. Redirects (branch, jump, trap) flush the queue, kill in-flight fetches and restart from the new PC.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 98 +++++++++
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   RESET_PC_DEFAULT : default PC after reset
//   ILEN, PC_STEP    : instruction width and PC increment
//   fetch_entry_t    : {pc, inst} pair held in the instruction queue
//   inflight_t       : {valid, kill, pc} record of an issued fetch
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          ILEN             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef struct packed {
    logic            valid;
    logic            kill;
    logic [ILEN-1:0] pc;
  } inflight_t;

  // Instructions are word aligned; the two low bits of a target are dropped.
  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with a registered head.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the queue (wins over push and pop)
//   push       : write push_data at the tail
//   pop        : remove the head (ignored when empty)
//   head_valid : queue holds at least one entry
//   head       : oldest entry, driven from a register
//   occ        : number of stored entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output logic             head_valid,
  output fetch_entry_t     head,
  output logic [OCC_W-1:0] occ
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     head_q, head_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] occ_after_pop;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (occ_q != '0) && !flush;
  assign do_push = push && !flush && (occ_q != OCC_W'(DEPTH));

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    head_d        = head_q;
    occ_after_pop = occ_q - OCC_W'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      occ_d = occ_after_pop + OCC_W'(do_push);
      // The head register is preloaded with whatever will sit at rd_ptr_d.
      // If the queue would otherwise be empty, that is the word being
      // written now, which has not reached the array yet.
      if (do_push && (occ_after_pop == '0)) begin
        head_d = push_data;
      end else if (occ_after_pop != '0) begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
    end
  end

  assign head_valid = (occ_q != '0);
  assign head       = head_q;
  assign occ        = occ_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and request issuer for a fixed-latency fetch unit.
//   clk, rst              : clock, synchronous active-high reset
//   fetch_en              : allow new requests
//   redirect_valid/_pc    : flush and restart at redirect_pc (word aligned)
//   mem_req, mem_addr     : one request per cycle to the fetch unit
//   mem_rvalid, mem_rdata : responses, exactly MEM_LAT cycles after request
//   inst_valid/inst/inst_pc, inst_ready : decoder valid/ready handshake
// Every request reserves a queue slot (occ + live < QDEPTH), because the
// fetch unit cannot be stalled once a request is in flight.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 4,
  parameter int          MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int OCC_W = $clog2(QDEPTH + 1);
  localparam int LIV_W = $clog2(MEM_LAT + 1);
  localparam int CRD_W = $clog2(QDEPTH + MEM_LAT + 1) + 1;

  logic [31:0]      pc_q, pc_d;
  // In-flight fetches, oldest in slot 0; valid entries are kept packed low.
  inflight_t        pipe_q [MEM_LAT];
  inflight_t        pipe_d [MEM_LAT];
  logic [MEM_LAT-1:0] live_vec;
  logic [LIV_W-1:0] live;
  logic [OCC_W-1:0] occ;
  logic             resp_pop, resp_push, deq, placed;
  fetch_entry_t     resp_entry, head;

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_live
      assign live_vec[gi] = pipe_q[gi].valid && !pipe_q[gi].kill;
    end
  endgenerate

  always_comb begin
    live = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      live = live + LIV_W'(live_vec[i]);
    end
  end

  // Killed fetches hold no credit: their responses are thrown away.
  assign mem_req  = !rst && fetch_en && !redirect_valid &&
                    ((CRD_W'(occ) + CRD_W'(live)) < CRD_W'(QDEPTH));
  assign mem_addr = pc_q;

  // A response with nothing in flight (e.g. for a pre-reset request) is ignored.
  assign resp_pop   = mem_rvalid && pipe_q[0].valid;
  assign resp_push  = resp_pop && !pipe_q[0].kill && !redirect_valid;
  assign resp_entry = '{pc: pipe_q[0].pc, inst: mem_rdata};
  assign deq        = inst_valid && inst_ready;

  always_comb begin
    pipe_d = pipe_q;
    pc_d   = pc_q;
    placed = 1'b0;
    if (resp_pop) begin
      for (int i = 0; i < MEM_LAT - 1; i++) begin
        pipe_d[i] = pipe_q[i + 1];
      end
      pipe_d[MEM_LAT-1] = '0;
    end
    if (redirect_valid) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_d[i].kill = 1'b1;
      end
      pc_d = align_pc(redirect_pc);
    end else if (mem_req) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        if (!placed && !pipe_d[i].valid) begin
          pipe_d[i] = '{valid: 1'b1, kill: 1'b0, pc: pc_q};
          placed    = 1'b1;
        end
      end
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // A decoder pop in a redirect cycle still completes; flush clears the rest.
  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_push),
    .push_data (resp_entry),
    .pop       (deq),
    .head_valid(inst_valid),
    .head      (head),
    .occ       (occ)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          QD     = 4;
  localparam int          LAT    = 2;
  localparam logic [31:0] B      = RST_PC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .QDEPTH(QD), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  // Fetch unit: answers every request two cycles later with addr ^ 0x1234.
  // It is deliberately not reset, so pre-reset requests still get answers.
  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, a2 = '0;
  always @(negedge clk) begin
    v2 = v1; a2 = a1;
    v1 = v0; a1 = a0;
    v0 = mem_req; a0 = mem_addr;
    mem_rvalid = v2;
    mem_rdata  = a2 ^ 32'h1234;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          cyc;
    bit          killed;
  } fl_t;

  fl_t         fl[$];   // issued fetches, oldest first
  logic [31:0] mq[$];   // PCs waiting for the decoder
  logic [31:0] m_pc = RST_PC;
  int          cyc = 0;
  bit          model_on = 1'b0;

  function automatic int m_live();
    int n = 0;
    foreach (fl[i]) if (!fl[i].killed) n++;
    return n;
  endfunction

  function automatic logic m_req();
    return !rst && fetch_en && !redirect_valid && ((mq.size() + m_live()) < QD);
  endfunction

  task automatic model_check();
    cmp("mem_req", 32'(mem_req), 32'(m_req()));
    cmp("mem_addr", mem_addr, m_pc);
    cmp("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
    cmp("occ", 32'(dut.u_queue.occ), 32'(mq.size()));
    if (mq.size() > 0) begin
      cmp("inst_pc", inst_pc, mq[0]);
      cmp("inst", inst, mq[0] ^ 32'h1234);
    end
  endtask

  task automatic model_update();
    fl_t  e;
    bit   resp;
    logic req;
    req = m_req();
    if (rst) begin
      m_pc = RST_PC;
      mq.delete();
      fl.delete();
    end else begin
      resp = (fl.size() > 0) && (fl[0].cyc + LAT == cyc);
      if (resp) e = fl.pop_front();
      if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        foreach (fl[i]) fl[i].killed = 1'b1;
        m_pc = redirect_pc & ~32'h3;
      end else begin
        if (resp && !e.killed) mq.push_back(e.pc);
        if (req) begin
          fl.push_back('{m_pc, cyc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic cycle_begin();
    #1;
    if (model_on) model_check();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    #1;
    model_on = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          chk, r, en, rdy, rdir;
    logic [31:0] rpc;
    bit          xreq;
    logic [31:0] xaddr;
    bit          xval;
    logic [31:0] xpc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit chk, bit r, bit en, bit rdy, bit rdir, logic [31:0] rpc,
                              bit xreq, logic [31:0] xaddr, bit xval, logic [31:0] xpc);
    tbl.push_back('{chk, r, en, rdy, rdir, rpc, xreq, xaddr, xval, xpc});
  endfunction

  function automatic void add_rst();
    add(0, 1, 1, 1, 0, 0, 0, RST_PC, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, RST_PC, 0, 0);
  endfunction

  initial begin
    // A: streaming with decoder always ready
    add_rst();
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h00, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h04, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h08, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h0C, 1, B + 32'h00);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h10, 1, B + 32'h04);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h14, 1, B + 32'h08);
    // B: decoder stalled, queue fills to 4 then drains
    add_rst();
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h00, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h04, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h08, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h0C, 1, B);
    add(1, 0, 1, 0, 0, 0, 0, B + 32'h10, 1, B);
    add(1, 0, 1, 0, 0, 0, 0, B + 32'h10, 1, B);
    add(1, 0, 1, 0, 0, 0, 0, B + 32'h10, 1, B);
    add(1, 0, 1, 1, 0, 0, 0, B + 32'h10, 1, B);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h10, 1, B + 32'h04);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h14, 1, B + 32'h08);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h18, 1, B + 32'h0C);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h1C, 1, B + 32'h10);
    // C: redirect with a response and a handshake in the same cycle
    add_rst();
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h00, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h04, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h08, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h0C, 1, B + 32'h00);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h10, 1, B + 32'h04);
    add(1, 0, 1, 1, 1, B + 32'h1002, 0, B + 32'h14, 1, B + 32'h08);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h1000, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h1004, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h1008, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h100C, 1, B + 32'h1000);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h1010, 1, B + 32'h1004);
    // D: reset with fetches in flight and entries queued
    add_rst();
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h00, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h04, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h08, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, B + 32'h0C, 1, B);
    add(1, 1, 1, 0, 0, 0, 0, B + 32'h10, 1, B);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h00, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h04, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h08, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, B + 32'h0C, 1, B);
    // E: redirect to the top of the address space, PC wraps
    add_rst();
    add(1, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, B, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 32'h0000_0000, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 32'h0000_0004, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 32'h0000_0008, 1, 32'hFFFF_FFFC);
    add(1, 0, 1, 1, 0, 0, 1, 32'h0000_000C, 1, 32'h0000_0000);

    foreach (tbl[i]) begin
      rst            = tbl[i].r;
      fetch_en       = tbl[i].en;
      inst_ready     = tbl[i].rdy;
      redirect_valid = tbl[i].rdir;
      redirect_pc    = tbl[i].rpc;
      cycle_begin();
      if (tbl[i].chk) begin
        cmp($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].xreq));
        cmp($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].xaddr);
        cmp($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].xval));
        if (tbl[i].xval) begin
          cmp($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].xpc);
          cmp($sformatf("row%0d inst", i), inst, tbl[i].xpc ^ 32'h1234);
        end
      end
      if (i == 1) begin
        cmp("reset inst", inst, 32'h0);
        cmp("reset inst_pc", inst_pc, 32'h0);
      end
      cycle_end();
    end

    // ---------------- randomized run against the model ----------------
    for (int k = 0; k < 2500; k++) begin
      rst            = ($urandom_range(63) == 0);
      fetch_en       = ($urandom_range(7) != 0);
      inst_ready     = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle_begin();
      cycle_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
